// File: rtl/hazard3_pwr_sequencer.sv
// Power-domain sequencer: turns the 4-phase pwrup_req/pwrup_ack handshake into a timed
// reset / clock / isolation / power-switch sequence for the switchable domain.
module hazard3_pwr_sequencer #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned CLK_CYCLES     = 2,
  parameter int unsigned ISO_CYCLES     = 2,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_always_on,
  input  logic rst,
  input  logic pwrup_req,
  output logic pwrup_ack,
  output logic pd_switch_en,
  input  logic pd_power_good,
  output logic pd_iso_en,
  output logic pd_rst_n,
  output logic pd_clk_en,
  output logic fault,
  input  logic fault_clr
);

  localparam int unsigned MAX_A      = (RST_CYCLES > CLK_CYCLES) ? RST_CYCLES : CLK_CYCLES;
  localparam int unsigned MAX_B      = (ISO_CYCLES > SETTLE_CYCLES) ? ISO_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_AB     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYCLES = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_ON          = 4'd0,
    S_RST_ASSERT  = 4'd1,
    S_CLK_OFF     = 4'd2,
    S_ISO_ON      = 4'd3,
    S_PWR_OFF     = 4'd4,
    S_OFF         = 4'd5,
    S_PWR_ON      = 4'd6,
    S_SETTLE      = 4'd7,
    S_ISO_OFF     = 4'd8,
    S_CLK_ON      = 4'd9,
    S_RST_RELEASE = 4'd10
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               sw_q, sw_d;
  logic               iso_q, iso_d;
  logic               rst_n_q, rst_n_d;
  logic               clk_en_q, clk_en_d;
  logic               fault_q, fault_d;
  logic               cnt_done;

  // A timed state of N cycles is entered with N-1 and left on the edge where the count is 0.
  function automatic logic [CNT_W-1:0] load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

  assign cnt_done = (cnt_q == '0);

  // NOTE: every always_comb output is given a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_done ? cnt_q : cnt_q - CNT_W'(1);
    ack_d    = ack_q;
    sw_d     = sw_q;
    iso_d    = iso_q;
    rst_n_d  = rst_n_q;
    clk_en_d = clk_en_q;
    fault_d  = fault_q & ~fault_clr;

    unique case (state_q)
      S_ON: if (!pwrup_req) begin
        rst_n_d = 1'b0;
        cnt_d   = load(RST_CYCLES);
        state_d = S_RST_ASSERT;
      end
      S_RST_ASSERT: if (cnt_done) begin
        clk_en_d = 1'b0;
        cnt_d    = load(CLK_CYCLES);
        state_d  = S_CLK_OFF;
      end
      S_CLK_OFF: if (cnt_done) begin
        iso_d   = 1'b1;
        cnt_d   = load(ISO_CYCLES);
        state_d = S_ISO_ON;
      end
      S_ISO_ON: if (cnt_done) begin
        sw_d    = 1'b0;
        cnt_d   = load(TIMEOUT_CYCLES);
        state_d = S_PWR_OFF;
      end
      S_PWR_OFF: if (!pd_power_good || cnt_done) begin
        // Rail still up at expiry is a timeout; the handshake completes regardless.
        if (pd_power_good) fault_d = 1'b1;
        ack_d   = 1'b0;
        state_d = S_OFF;
      end
      S_OFF: if (pwrup_req) begin
        sw_d    = 1'b1;
        cnt_d   = load(TIMEOUT_CYCLES);
        state_d = S_PWR_ON;
      end
      S_PWR_ON: if (pd_power_good || cnt_done) begin
        if (!pd_power_good) fault_d = 1'b1;
        cnt_d   = load(SETTLE_CYCLES);
        state_d = S_SETTLE;
      end
      S_SETTLE: if (cnt_done) begin
        iso_d   = 1'b0;
        cnt_d   = load(ISO_CYCLES);
        state_d = S_ISO_OFF;
      end
      S_ISO_OFF: if (cnt_done) begin
        clk_en_d = 1'b1;
        cnt_d    = load(CLK_CYCLES);
        state_d  = S_CLK_ON;
      end
      S_CLK_ON: if (cnt_done) begin
        rst_n_d = 1'b1;
        cnt_d   = load(RST_CYCLES);
        state_d = S_RST_RELEASE;
      end
      S_RST_RELEASE: if (cnt_done) begin
        ack_d   = 1'b1;
        state_d = S_ON;
      end
      default: begin
        state_d  = S_ON;
        cnt_d    = '0;
        ack_d    = 1'b1;
        sw_d     = 1'b1;
        iso_d    = 1'b0;
        rst_n_d  = 1'b1;
        clk_en_d = 1'b1;
        fault_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_always_on) begin
    if (rst) begin
      state_q  <= S_ON;
      cnt_q    <= '0;
      ack_q    <= 1'b1;
      sw_q     <= 1'b1;
      iso_q    <= 1'b0;
      rst_n_q  <= 1'b1;
      clk_en_q <= 1'b1;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      sw_q     <= sw_d;
      iso_q    <= iso_d;
      rst_n_q  <= rst_n_d;
      clk_en_q <= clk_en_d;
      fault_q  <= fault_d;
    end
  end

  assign pwrup_ack    = ack_q;
  assign pd_switch_en = sw_q;
  assign pd_iso_en    = iso_q;
  assign pd_rst_n     = rst_n_q;
  assign pd_clk_en    = clk_en_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_hazard3_pwr_sequencer.sv
// Scoreboard bench: stimulus queues expected output vectors per edge, a negedge monitor
// pops and compares them and flags any output change nobody announced.
module tb_hazard3_pwr_sequencer;

  // Output vector bit order: {ack, switch_en, iso_en, rst_n, clk_en, fault}
  localparam logic [5:0] V_RESET   = 6'b110110;
  localparam logic [5:0] V_RSTLOW  = 6'b110010;
  localparam logic [5:0] V_CLKOFF  = 6'b110000;
  localparam logic [5:0] V_ISOON   = 6'b111000;
  localparam logic [5:0] V_PWROFF  = 6'b101000;
  localparam logic [5:0] V_OFF     = 6'b001000;
  localparam logic [5:0] V_PWRON   = 6'b011000;
  localparam logic [5:0] V_ISOOFF  = 6'b010000;
  localparam logic [5:0] V_CLKON   = 6'b010010;
  localparam logic [5:0] V_RSTREL  = 6'b010110;

  typedef struct {
    int unsigned at;
    int          dut;
    logic [5:0]  vec;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, pg, clr;
  wire  [1:0] ack, sw, iso, rstn, clken, flt;

  always #5 clk = ~clk;

  hazard3_pwr_sequencer dut (
    .clk_always_on(clk), .rst(rst),
    .pwrup_req(req[0]), .pwrup_ack(ack[0]),
    .pd_switch_en(sw[0]), .pd_power_good(pg[0]),
    .pd_iso_en(iso[0]), .pd_rst_n(rstn[0]), .pd_clk_en(clken[0]),
    .fault(flt[0]), .fault_clr(clr[0])
  );

  hazard3_pwr_sequencer #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk_always_on(clk), .rst(rst),
    .pwrup_req(req[1]), .pwrup_ack(ack[1]),
    .pd_switch_en(sw[1]), .pd_power_good(pg[1]),
    .pd_iso_en(iso[1]), .pd_rst_n(rstn[1]), .pd_clk_en(clken[1]),
    .fault(flt[1]), .fault_clr(clr[1])
  );

  int unsigned edge_n = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          viol = 0;
  bit          free_run = 1'b1;
  exp_t        exp_q[$];
  logic [5:0]  prev [2];

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [5:0] outs(input int d);
    return {ack[d], sw[d], iso[d], rstn[d], clken[d], flt[d]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, edge_n);
  endtask

  task automatic expect_at(input int d, input int unsigned at, input logic [5:0] v, input string name);
    exp_t e;
    e.at = at; e.dut = d; e.vec = v; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int unsigned n);
    while (edge_n + 1 < n) @(negedge clk);
  endtask

  task automatic expect_down(input int d, input int unsigned e0, input int unsigned pwroff_len,
                             input logic [5:0] v_end, input string tag);
    expect_at(d, e0,              V_RSTLOW, {tag, "_rst_n_low"});
    expect_at(d, e0 + 4,          V_CLKOFF, {tag, "_clk_off"});
    expect_at(d, e0 + 6,          V_ISOON,  {tag, "_iso_on"});
    expect_at(d, e0 + 8,          V_PWROFF, {tag, "_switch_off"});
    expect_at(d, e0 + 8 + pwroff_len, v_end, {tag, "_ack_low"});
  endtask

  always @(negedge clk) begin
    logic [5:0] cur [2];
    bit         consumed [2];
    exp_t       e;
    for (int d = 0; d < 2; d++) begin
      cur[d]      = outs(d);
      consumed[d] = 1'b0;
    end
    while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
      e = exp_q.pop_front();
      if (e.at < edge_n) check({e.name, "_missed"}, edge_n, e.at);
      else begin
        check(e.name, {26'd0, cur[e.dut]}, {26'd0, e.vec});
        consumed[e.dut] = 1'b1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (!free_run && cur[d] !== prev[d] && !consumed[d])
        check($sformatf("unexpected_change_dut%0d", d), {26'd0, cur[d]}, {26'd0, prev[d]});
      if (clken[d] === 1'b0 && rstn[d] !== 1'b0) viol++;
      if (sw[d] === 1'b0 && iso[d] !== 1'b1) viol++;
      prev[d] = cur[d];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
    $fatal(1);
  end

  initial begin
    int unsigned e0, e1;
    rst = 1'b1; req = 2'b11; pg = 2'b11; clr = 2'b00;
    @(negedge clk);

    // Reset and hold
    expect_at(0, 1, V_RESET, "reset_dut0");
    expect_at(1, 1, V_RESET, "reset_dut1");
    goto(3);
    rst = 1'b0;
    free_run = 1'b0;
    expect_at(0, 22, V_RESET, "hold_dut0");
    expect_at(1, 22, V_RESET, "hold_dut1");
    goto(23);

    // Power-down, rail drops 3 cycles after switch-off
    e0 = edge_n + 1;
    req[0] = 1'b0;
    expect_down(0, e0, 4, V_OFF, "down");
    goto(e0 + 12); pg[0] = 1'b0;
    goto(e0 + 15);

    // Power-up, rail rises 5 cycles after switch-on
    e0 = edge_n + 1;
    req[0] = 1'b1;
    expect_at(0, e0, V_PWRON, "up_switch_on");
    goto(e0 + 6); pg[0] = 1'b1;
    expect_at(0, e0 + 22, V_ISOOFF, "up_iso_off");
    expect_at(0, e0 + 24, V_CLKON,  "up_clk_on");
    expect_at(0, e0 + 26, V_RSTREL, "up_rst_release");
    expect_at(0, e0 + 30, V_RESET,  "up_ack_high");
    goto(e0 + 33);

    // Power-down timeout (rail stuck high), then fault clear
    e0 = edge_n + 1;
    req[1] = 1'b0;
    expect_down(1, e0, 8, 6'b001001, "to_down");
    goto(e0 + 18); clr[1] = 1'b1;
    expect_at(1, e0 + 18, V_OFF, "to_fault_clear");
    goto(e0 + 19); clr[1] = 1'b0;

    // Power-up timeout (rail stuck low) with clear on the same edge: set wins
    e1 = edge_n + 1;
    req[1] = 1'b1; pg[1] = 1'b0;
    expect_at(1, e1, V_PWRON, "to_up_switch_on");
    goto(e1 + 8); clr[1] = 1'b1;
    expect_at(1, e1 + 8, 6'b011001, "to_up_set_wins");
    goto(e1 + 9); clr[1] = 1'b0;
    goto(e1 + 12); clr[1] = 1'b1;
    expect_at(1, e1 + 12, V_PWRON, "to_up_fault_clear");
    goto(e1 + 13); clr[1] = 1'b0; pg[1] = 1'b1;
    expect_at(1, e1 + 24, V_ISOOFF, "to_up_iso_off");
    expect_at(1, e1 + 26, V_CLKON,  "to_up_clk_on");
    expect_at(1, e1 + 28, V_RSTREL, "to_up_rst_release");
    expect_at(1, e1 + 32, V_RESET,  "to_up_ack_high");
    goto(e1 + 35);

    // Request re-rises mid power-down: no abort, OFF for one cycle, then full power-up
    e0 = edge_n + 1;
    req[0] = 1'b0;
    expect_down(0, e0, 4, V_OFF, "noabort_down");
    goto(e0 + 2); req[0] = 1'b1;
    goto(e0 + 12); pg[0] = 1'b0;
    e1 = e0 + 13;
    expect_at(0, e1, V_PWRON, "noabort_switch_on");
    goto(e1 + 6); pg[0] = 1'b1;
    expect_at(0, e1 + 22, V_ISOOFF, "noabort_iso_off");
    expect_at(0, e1 + 24, V_CLKON,  "noabort_clk_on");
    expect_at(0, e1 + 26, V_RSTREL, "noabort_rst_release");
    expect_at(0, e1 + 30, V_RESET,  "noabort_ack_high");
    goto(e1 + 33);

    // Reset asserted in SETTLE, then prove the sequencer sits in ON
    e0 = edge_n + 1;
    req[0] = 1'b0;
    expect_down(0, e0, 4, V_OFF, "settle_down");
    goto(e0 + 12); pg[0] = 1'b0;
    goto(e0 + 14); req[0] = 1'b1;
    e1 = e0 + 14;
    expect_at(0, e1, V_PWRON, "settle_switch_on");
    goto(e1 + 6); pg[0] = 1'b1;
    goto(e1 + 10); rst = 1'b1;
    expect_at(0, e1 + 10, V_RESET, "settle_reset");
    goto(e1 + 11); rst = 1'b0;
    goto(e1 + 14); req[0] = 1'b0;
    expect_down(0, e1 + 14, 4, V_OFF, "after_reset_down");
    goto(e1 + 26); pg[0] = 1'b0;
    goto(e1 + 30);

    // Random request toggling; only invariants are watched
    free_run = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 39) == 0) req[d] = ~req[d];
        if ($urandom_range(0, 3) != 0) pg[d] = sw[d];
        clr[d] = ($urandom_range(0, 99) == 0);
      end
    end

    check("invariant_violations", viol, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
